// File: rtl/cpu_run_ctrl_pkg.sv
// Shared state and stop-reason encodings for the cpu_run_ctrl run-control sequencer.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_CAL = 2'd1,
        ST_RUN      = 2'd2,
        ST_STEP     = 2'd3
    } run_state_e;

    typedef enum logic [1:0] {
        RSN_CMD       = 2'd0,
        RSN_STEP_DONE = 2'd1,
        RSN_BREAK     = 2'd2,
        RSN_CAL_LOST  = 2'd3
    } stop_reason_e;

endpackage

// File: rtl/cpu_run_ctrl_run_cycle_cnt.sv
// Saturating executed-cycle counter; clear has priority over enable.
module run_cycle_cnt #(
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CYC_W-1:0] o_cnt
);

    logic [CYC_W-1:0] r_cnt;

    // Counter register: clear on run start, count enabled cycles, stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CYC_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CYC_W{1'b0}};
        end else if (i_en && (r_cnt != {CYC_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CYC_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: turns monitor start/stop/step commands into registered start/quit pulses.
// Optional breakpoint stop is enabled by defining CPU_BREAK_EN.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int STEP_W = 16,
    parameter int CYC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_cmd,
    input  logic              stop_cmd,
    input  logic              step_cmd,
    input  logic [STEP_W-1:0] step_num,
    input  logic              init_calib_complete,
    input  logic              stall,
    input  logic [31:0]       pc_id,
    input  logic              bp_en,
    input  logic [31:0]       bp_addr,
    output logic              cpu_start,
    output logic              quit_cmd,
    output logic              run_busy,
    output logic [1:0]        stop_reason,
    output logic [CYC_W-1:0]  run_cycles
);

    run_state_e   r_state;
    run_state_e   w_state_nxt;
    stop_reason_e r_stop_reason;
    stop_reason_e w_reason_nxt;
    logic [STEP_W-1:0] r_step_cnt;
    logic r_cpu_start;
    logic r_quit_cmd;
    logic r_run_busy;
    logic w_start_go;
    logic w_quit_go;
    logic w_step_load;
    logic w_bp_hit;
    logic w_running;

    assign w_running = (r_state == ST_RUN) || (r_state == ST_STEP);

`ifdef CPU_BREAK_EN
    assign w_bp_hit = w_running && !stall && bp_en && (pc_id == bp_addr);
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{bp_en, bp_addr, pc_id};
    assign w_bp_hit    = 1'b0;
`endif

    // Next-state and pulse decisions; priority CAL_LOST > stop > BREAK > STEP_DONE.
    always_comb begin
        w_state_nxt  = r_state;
        w_reason_nxt = r_stop_reason;
        w_start_go   = 1'b0;
        w_quit_go    = 1'b0;
        w_step_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (stop_cmd) begin
                    w_state_nxt = ST_IDLE;
                end else if (start_cmd) begin
                    if (init_calib_complete) begin
                        w_start_go   = 1'b1;
                        w_reason_nxt = RSN_CMD;
                        w_state_nxt  = ST_RUN;
                    end else begin
                        w_state_nxt = ST_WAIT_CAL;
                    end
                end else if (step_cmd && (step_num != {STEP_W{1'b0}}) && init_calib_complete) begin
                    w_start_go   = 1'b1;
                    w_step_load  = 1'b1;
                    w_reason_nxt = RSN_CMD;
                    w_state_nxt  = ST_STEP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_CAL: begin
                if (stop_cmd) begin
                    w_reason_nxt = RSN_CMD;
                    w_state_nxt  = ST_IDLE;
                end else if (init_calib_complete) begin
                    w_start_go   = 1'b1;
                    w_reason_nxt = RSN_CMD;
                    w_state_nxt  = ST_RUN;
                end else begin
                    w_state_nxt = ST_WAIT_CAL;
                end
            end
            ST_RUN, ST_STEP: begin
                if (!init_calib_complete) begin
                    // The status block stops itself when calibration is lost, so no quit pulse.
                    w_reason_nxt = RSN_CAL_LOST;
                    w_state_nxt  = ST_IDLE;
                end else if (stop_cmd) begin
                    w_quit_go    = 1'b1;
                    w_reason_nxt = RSN_CMD;
                    w_state_nxt  = ST_IDLE;
                end else if (w_bp_hit) begin
                    w_quit_go    = 1'b1;
                    w_reason_nxt = RSN_BREAK;
                    w_state_nxt  = ST_IDLE;
                end else if ((r_state == ST_STEP) && !stall &&
                             (r_step_cnt == {{(STEP_W-1){1'b0}}, 1'b1})) begin
                    w_quit_go    = 1'b1;
                    w_reason_nxt = RSN_STEP_DONE;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, reason and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_stop_reason <= RSN_CMD;
            r_cpu_start   <= 1'b0;
            r_quit_cmd    <= 1'b0;
            r_run_busy    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_stop_reason <= w_reason_nxt;
            r_cpu_start   <= w_start_go;
            r_quit_cmd    <= w_quit_go;
            r_run_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    // Step down-counter: loaded on step start, decremented on each non-stalled STEP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cnt <= {STEP_W{1'b0}};
        end else if (w_step_load) begin
            r_step_cnt <= step_num;
        end else if (w_state_nxt == ST_IDLE) begin
            r_step_cnt <= {STEP_W{1'b0}};
        end else if ((r_state == ST_STEP) && !stall && (r_step_cnt != {STEP_W{1'b0}})) begin
            r_step_cnt <= r_step_cnt - {{(STEP_W-1){1'b0}}, 1'b1};
        end else begin
            r_step_cnt <= r_step_cnt;
        end
    end

    run_cycle_cnt #(
        .CYC_W (CYC_W)
    ) u_run_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_start_go),
        .i_en  (w_running && !stall),
        .o_cnt (run_cycles)
    );

    assign cpu_start   = r_cpu_start;
    assign quit_cmd    = r_quit_cmd;
    assign run_busy    = r_run_busy;
    assign stop_reason = r_stop_reason;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed table-driven bench for cpu_run_ctrl plus reset and breakpoint sequences.
module tb_cpu_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_cmd;
    logic        stop_cmd;
    logic        step_cmd;
    logic [15:0] step_num;
    logic        calib;
    logic        stall;
    logic [31:0] pc_id;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        cpu_start;
    logic        quit_cmd;
    logic        run_busy;
    logic [1:0]  stop_reason;
    logic [31:0] run_cycles;

    int total;
    int bad;

    typedef struct {
        logic        start;
        logic        stop;
        logic        step;
        logic [15:0] num;
        logic        cal;
        logic        stl;
        logic        e_start;
        logic        e_quit;
        logic        e_busy;
        logic [1:0]  e_reason;
        logic [31:0] e_cyc;
    } vec_t;

    vec_t vecs[$];

    cpu_run_ctrl u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start_cmd           (start_cmd),
        .stop_cmd            (stop_cmd),
        .step_cmd            (step_cmd),
        .step_num            (step_num),
        .init_calib_complete (calib),
        .stall               (stall),
        .pc_id               (pc_id),
        .bp_en               (bp_en),
        .bp_addr             (bp_addr),
        .cpu_start           (cpu_start),
        .quit_cmd            (quit_cmd),
        .run_busy            (run_busy),
        .stop_reason         (stop_reason),
        .run_cycles          (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic sc, input logic [15:0] n,
                       input logic cl, input logic sl, input logic es, input logic eq,
                       input logic eb, input logic [1:0] er, input logic [31:0] ec);
        vec_t v;
        v.start = st; v.stop = sp; v.step = sc; v.num = n; v.cal = cl; v.stl = sl;
        v.e_start = es; v.e_quit = eq; v.e_busy = eb; v.e_reason = er; v.e_cyc = ec;
        vecs.push_back(v);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start_cmd = 1'b0; stop_cmd = 1'b0; step_cmd = 1'b0; step_num = 16'd0;
        calib = 1'b1; stall = 1'b0; pc_id = 32'h0; bp_en = 1'b0; bp_addr = 32'h0;

        //   st    sp    sc    num    cal   stl   es    eq    eb    reason cyc
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0); // idle
        add(1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0); // start+stop no-op
        add(1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0); // step 0 ignored
        add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'd0); // start
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd1);
        add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd2); // start ignored
        add(1'b0, 1'b0, 1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd3); // step ignored
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'd3); // stalled
        add(1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd4); // stop
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd4); // hold
        add(1'b0, 1'b0, 1'b1, 16'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'd0); // step 5
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd1);
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'd1);
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd2);
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'd2);
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd3);
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'd3);
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd4);
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'd5); // step done
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd5);
        add(1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd5); // step no calib
        add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'd0); // start
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd1);
        add(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 32'd2); // cal lost beats stop
        add(1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'd0); // step 1
        add(1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd1); // stop + done
        add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd1); // wait cal
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd1);
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'd0); // calib rises
        add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd1);
        add(1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd2);
        add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd2); // wait cal
        add(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd2); // stop in wait

        #3;
        chk("rst_start", {31'd0, cpu_start}, 32'd0);
        chk("rst_quit", {31'd0, quit_cmd}, 32'd0);
        chk("rst_busy", {31'd0, run_busy}, 32'd0);
        chk("rst_reason", {30'd0, stop_reason}, 32'd0);
        chk("rst_cycles", run_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start_cmd = vecs[i].start; stop_cmd = vecs[i].stop; step_cmd = vecs[i].step;
            step_num = vecs[i].num; calib = vecs[i].cal; stall = vecs[i].stl;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_start", i), {31'd0, cpu_start}, {31'd0, vecs[i].e_start});
            chk($sformatf("v%0d_quit", i), {31'd0, quit_cmd}, {31'd0, vecs[i].e_quit});
            chk($sformatf("v%0d_busy", i), {31'd0, run_busy}, {31'd0, vecs[i].e_busy});
            chk($sformatf("v%0d_reason", i), {30'd0, stop_reason}, {30'd0, vecs[i].e_reason});
            chk($sformatf("v%0d_cycles", i), run_cycles, vecs[i].e_cyc);
        end

        // Asynchronous reset in the middle of a step run.
        @(negedge clk);
        start_cmd = 1'b0; stop_cmd = 1'b0; calib = 1'b1; stall = 1'b0;
        step_cmd = 1'b1; step_num = 16'd100;
        @(negedge clk);
        step_cmd = 1'b0; step_num = 16'd0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", {31'd0, run_busy}, 32'd1);
        chk("pre_rst_cycles", run_cycles, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_start", {31'd0, cpu_start}, 32'd0);
        chk("arst_quit", {31'd0, quit_cmd}, 32'd0);
        chk("arst_busy", {31'd0, run_busy}, 32'd0);
        chk("arst_reason", {30'd0, stop_reason}, 32'd0);
        chk("arst_cycles", run_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Breakpoint match while running.
        @(negedge clk);
        start_cmd = 1'b1;
        @(negedge clk);
        start_cmd = 1'b0;
        bp_en = 1'b1; bp_addr = 32'h0000_0100; pc_id = 32'h0000_0100;
        @(posedge clk);
        #1;
`ifdef CPU_BREAK_EN
        chk("bp_quit", {31'd0, quit_cmd}, 32'd1);
        chk("bp_busy", {31'd0, run_busy}, 32'd0);
        chk("bp_reason", {30'd0, stop_reason}, 32'd2);
`else
        chk("bp_quit", {31'd0, quit_cmd}, 32'd0);
        chk("bp_busy", {31'd0, run_busy}, 32'd1);
        chk("bp_reason", {30'd0, stop_reason}, 32'd0);
`endif
        @(negedge clk);
        bp_en = 1'b0; pc_id = 32'h0;
        stop_cmd = 1'b1;
        @(negedge clk);
        stop_cmd = 1'b0;
        @(posedge clk);
        #1;
        chk("end_busy", {31'd0, run_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
